// File: rtl/gtx_frame_rx_pkg.sv
// Shared constants and state types for the GTX receive deframer.
package gtx_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [1:0] CTRL_HDR  = 2'b01;
    localparam logic [1:0] CTRL_DATA = 2'b00;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } frame_state_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Number of 16-bit link words needed to carry a payload of the given width.
    function automatic int words_for(input int width);
        return (width + 15) / 16;
    endfunction

endpackage

// File: rtl/gtx_frame_rx_if.sv
// Receive-side bundle between the GTX wrapper (master) and the deframer (slave).
interface gtx_frame_rx_if #(
    parameter int DATA_WIDTH = 2
);
    logic [1:0]            ctrl_i;
    logic [15:0]           data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  lock_o;
    logic [15:0]           err_cnt_o;

    modport master (
        output ctrl_i, data_i,
        input  data_o, valid_o, lock_o, err_cnt_o
    );

    modport slave (
        input  ctrl_i, data_i,
        output data_o, valid_o, lock_o, err_cnt_o
    );
endinterface

// File: rtl/gtx_frame_rx_link_lock.sv
// Link lock tracker: counts consecutive good/bad frame strobes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   UNLOCKED | counting consecutive good frames toward LOCK_CNT
//   LOCKED   | counting consecutive bad frames toward UNLOCK_CNT
//
// lock_d_o is the lock value that will be registered at the next edge; the
// deframer uses it to release data on the very frame that achieves lock.
module link_lock
    import gtx_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic good_i,
    input  logic bad_i,
    output logic lock_o,
    output logic lock_d_o
);

    lock_state_t state_q;
    logic [3:0]  good_cnt_q;
    logic [3:0]  bad_cnt_q;
    logic        lock_q;

    assign lock_d_o = (state_q == LOCKED)
                    ? !(bad_i && (bad_cnt_q == 4'(UNLOCK_CNT - 1)))
                    : (good_i && (good_cnt_q == 4'(LOCK_CNT - 1)));
    assign lock_o   = lock_q;

    // Lock FSM with its run counters and registered lock output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_q <= lock_d_o;
            case (state_q)
                UNLOCKED: begin
                    if (good_i) begin
                        if (lock_d_o) begin
                            state_q    <= LOCKED;
                            good_cnt_q <= '0;
                            bad_cnt_q  <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 4'd1;
                        end
                    end else if (bad_i) begin
                        good_cnt_q <= '0;
                    end
                end
                LOCKED: begin
                    if (good_i) begin
                        bad_cnt_q <= '0;
                    end else if (bad_i) begin
                        good_cnt_q <= '0;
                        if (!lock_d_o) begin
                            state_q   <= UNLOCKED;
                            bad_cnt_q <= '0;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: rtl/gtx_frame_rx.sv
// Receive deframer for the 8b/10b GTX link (rxusrclk2 domain).
// Frame: K28.5 header carrying a sequence byte, then ceil(DATA_WIDTH/16)
// payload words, LSB word first.
// Optional build macro GTX_FRAME_RX_SEQ_CHECK_EN enables sequence checking.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | waiting for a header; all other words ignored silently
//   PAYLOAD | collecting payload words; a header here resyncs
module gtx_frame_rx
    import gtx_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gtx_frame_rx_if.slave     rx
);

    localparam int NW = words_for(DATA_WIDTH);

    frame_state_t          state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [15:0]           err_cnt_q;

    logic            is_hdr;
    logic            is_data;
    logic            last_word;
    logic            seq_ok;
    logic            good;
    logic            bad;
    logic            hdr_take;
    logic            word_store;
    logic            lock;
    logic            lock_d;
    logic [NW*16-1:0] frame_w;

    assign is_hdr  = (rx.ctrl_i == CTRL_HDR) && (rx.data_i[7:0] == K28_5);
    assign is_data = (rx.ctrl_i == CTRL_DATA);

    // Classify the incoming word against the current framing state.
    always_comb begin
        good       = 1'b0;
        bad        = 1'b0;
        hdr_take   = 1'b0;
        word_store = 1'b0;
        case (state_q)
            HUNT: hdr_take = is_hdr;
            PAYLOAD: begin
                if (is_data) begin
                    if (last_word) begin
                        good = seq_ok;
                        bad  = !seq_ok;
                    end else begin
                        word_store = 1'b1;
                    end
                end else begin
                    // A header here both ends the current frame as bad and starts the next one.
                    bad      = 1'b1;
                    hdr_take = is_hdr;
                end
            end
            default: ;
        endcase
    end

    // The final word is never stored; it is spliced straight from the bus.
    if (NW > 1) begin : g_multi
        localparam int IDXW = $clog2(NW);
        logic [IDXW-1:0]      idx_q;
        logic [16*(NW-1)-1:0] lo_q;

        // Word index and storage for all but the last payload word.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                idx_q <= '0;
                lo_q  <= '0;
            end else if (hdr_take) begin
                idx_q <= '0;
            end else if (word_store) begin
                lo_q[idx_q*16 +: 16] <= rx.data_i;
                idx_q                <= idx_q + 1'b1;
            end
        end

        assign last_word = (idx_q == IDXW'(NW - 1));
        assign frame_w   = {rx.data_i, lo_q};
    end else begin : g_single
        assign last_word = 1'b1;
        assign frame_w   = rx.data_i;
    end

`ifdef GTX_FRAME_RX_SEQ_CHECK_EN
    logic [7:0] seq_q;
    logic [7:0] ref_q;
    logic       ref_vld_q;

    assign seq_ok = !ref_vld_q || (seq_q == ref_q + 8'd1);

    // Track the current frame's sequence and the last good frame's as reference.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_q     <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
        end else begin
            if (hdr_take) begin
                seq_q <= rx.data_i[15:8];
            end
            if (good) begin
                ref_q     <= seq_q;
                ref_vld_q <= 1'b1;
            end else if (bad) begin
                ref_vld_q <= 1'b0;
            end
        end
    end
`else
    assign seq_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{frame_w, rx.data_i[15:8], word_store};

    link_lock #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_link_lock (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .good_i   (good),
        .bad_i    (bad),
        .lock_o   (lock),
        .lock_d_o (lock_d)
    );

    // Deframe FSM plus registered data, valid pulse and saturating error count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= HUNT;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            valid_q <= good && lock_d;
            if (good && lock_d) begin
                data_q <= frame_w[DATA_WIDTH-1:0];
            end
            if (bad && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            case (state_q)
                HUNT:    if (hdr_take) state_q <= PAYLOAD;
                PAYLOAD: if ((good || bad) && !hdr_take) state_q <= HUNT;
                default: state_q <= HUNT;
            endcase
        end
    end

    assign rx.data_o    = data_q;
    assign rx.valid_o   = valid_q;
    assign rx.lock_o    = lock;
    assign rx.err_cnt_o = err_cnt_q;

endmodule
